// File: rtl/opm_wseq_pkg.sv
// Shared types for the OPM write sequencer: FSM states, command layout and
// the bus-pin encoding driven while each state is active.
package opm_wseq_pkg;

    localparam int CMD_W = 16;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        GAP
    } wseq_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wseq_cmd_t;

    // drive=0 means A0/D keep their previous values and the strobes are released
    typedef struct packed {
        logic cs_n;
        logic wr_n;
        logic a0;
        logic drive;
    } bus_ctl_t;

    localparam bus_ctl_t CTL_A_SETUP  = '{cs_n: 1'b0, wr_n: 1'b1, a0: 1'b0, drive: 1'b1};
    localparam bus_ctl_t CTL_A_STROBE = '{cs_n: 1'b0, wr_n: 1'b0, a0: 1'b0, drive: 1'b1};
    localparam bus_ctl_t CTL_A_HOLD   = '{cs_n: 1'b1, wr_n: 1'b1, a0: 1'b0, drive: 1'b1};
    localparam bus_ctl_t CTL_D_SETUP  = '{cs_n: 1'b0, wr_n: 1'b1, a0: 1'b1, drive: 1'b1};
    localparam bus_ctl_t CTL_D_STROBE = '{cs_n: 1'b0, wr_n: 1'b0, a0: 1'b1, drive: 1'b1};
    localparam bus_ctl_t CTL_D_HOLD   = '{cs_n: 1'b1, wr_n: 1'b1, a0: 1'b1, drive: 1'b1};
    localparam bus_ctl_t CTL_RELEASE  = '{cs_n: 1'b1, wr_n: 1'b1, a0: 1'b0, drive: 1'b0};

    function automatic bus_ctl_t state_ctl(input wseq_state_t s);
        bus_ctl_t c;
        case (s)
            A_SETUP:  c = CTL_A_SETUP;
            A_STROBE: c = CTL_A_STROBE;
            A_HOLD:   c = CTL_A_HOLD;
            D_SETUP:  c = CTL_D_SETUP;
            D_STROBE: c = CTL_D_STROBE;
            D_HOLD:   c = CTL_D_HOLD;
            default:  c = CTL_RELEASE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/opm_wseq_fifo.sv
// Command FIFO for the write sequencer. Head is presented combinationally;
// a push is refused when full even if a pop happens in the same cycle.
module opm_wseq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     ready,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign ready   = (level != LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && ready;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/opm_write_sequencer.sv
// Replays buffered (address, data) commands as two-phase YM2151 bus writes
// toward IKA2151, with programmable setup/strobe/hold widths and a gap.
module opm_write_sequencer
    import opm_wseq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SETUP_CYC  = 15,
    parameter int STROBE_CYC = 20,
    parameter int HOLD_CYC   = 15,
    parameter int GAP_CYC    = 64
) (
    input  logic                         i_EMUCLK,
    input  logic                         i_RST_n,
    input  logic                         i_CMD_VALID,
    output logic                         o_CMD_READY,
    input  logic [7:0]                   i_CMD_ADDR,
    input  logic [7:0]                   i_CMD_DATA,
    output logic                         o_CS_n,
    output logic                         o_WR_n,
    output logic                         o_A0,
    output logic [7:0]                   o_D,
    output logic                         o_BUSY,
    output logic [$clog2(FIFO_DEPTH):0]  o_LEVEL
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam bit               NO_GAP    = (GAP_CYC == 0);

    wseq_state_t      state;
    logic [CNT_W-1:0] cnt;
    wseq_cmd_t        cmd;
    logic [CMD_W-1:0] head_bits;
    logic             fifo_empty;
    logic             fifo_ready;
    logic             last;
    logic             pop;
    bus_ctl_t         ctl;

    logic             cs_n;
    logic             wr_n;
    logic             a0;
    logic [7:0]       d;
    logic             busy;

    opm_wseq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (i_EMUCLK),
        .rst_n     (i_RST_n),
        .push      (i_CMD_VALID),
        .push_data ({i_CMD_ADDR, i_CMD_DATA}),
        .ready     (fifo_ready),
        .pop       (pop),
        .head      (head_bits),
        .empty     (fifo_empty),
        .level     (o_LEVEL)
    );

    assign last = (cnt == '0);

    // A new command starts from IDLE or directly out of the final gap/hold
    // cycle, so back-to-back commands never spend a cycle in IDLE.
    assign pop = !fifo_empty &&
                 ((state == IDLE) ||
                  (last && ((state == GAP) || (state == D_HOLD && NO_GAP))));

    always_comb begin
        ctl = state_ctl(state);
    end

    // Bus pins are registered from the current state, so they trail the state
    // by one cycle; every width is preserved and WR_n can never fall with CS_n.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state <= IDLE;
            cnt   <= '0;
            cmd   <= '0;
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
            a0    <= 1'b0;
            d     <= 8'h00;
            busy  <= 1'b0;
        end else begin
            busy <= (state != IDLE) || !fifo_empty;

            if (ctl.drive) begin
                cs_n <= ctl.cs_n;
                wr_n <= ctl.wr_n;
                a0   <= ctl.a0;
                d    <= ctl.a0 ? cmd.data : cmd.addr;
            end else begin
                cs_n <= 1'b1;
                wr_n <= 1'b1;
            end

            if (pop) begin
                state <= A_SETUP;
                cmd   <= wseq_cmd_t'(head_bits);
                cnt   <= SETUP_LD;
            end else if (state != IDLE) begin
                if (!last) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    case (state)
                        A_SETUP: begin
                            state <= A_STROBE;
                            cnt   <= STROBE_LD;
                        end
                        A_STROBE: begin
                            state <= A_HOLD;
                            cnt   <= HOLD_LD;
                        end
                        A_HOLD: begin
                            state <= D_SETUP;
                            cnt   <= SETUP_LD;
                        end
                        D_SETUP: begin
                            state <= D_STROBE;
                            cnt   <= STROBE_LD;
                        end
                        D_STROBE: begin
                            state <= D_HOLD;
                            cnt   <= HOLD_LD;
                        end
                        D_HOLD: begin
                            if (NO_GAP) begin
                                state <= IDLE;
                            end else begin
                                state <= GAP;
                                cnt   <= GAP_LD;
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign o_CMD_READY = fifo_ready;
    assign o_CS_n      = cs_n;
    assign o_WR_n      = wr_n;
    assign o_A0        = a0;
    assign o_D         = d;
    assign o_BUSY      = busy;

endmodule

// File: tb/tb_opm_write_sequencer.sv
// Scoreboard bench for opm_write_sequencer: one instance with default timing,
// one with minimal widths and no gap; a bus monitor per instance checks commands.
module tb_opm_write_sequencer;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         spacing;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic       rst_a, valid_a, ready_a, cs_a, wr_a, a0_a, busy_a;
    logic [7:0] addr_a, data_a, d_a;
    logic [3:0] level_a;
    logic       rst_b, valid_b, ready_b, cs_b, wr_b, a0_b, busy_b;
    logic [7:0] addr_b, data_b, d_b;
    logic [2:0] level_b;

    opm_write_sequencer dut_a (
        .i_EMUCLK (clk), .i_RST_n (rst_a),
        .i_CMD_VALID (valid_a), .o_CMD_READY (ready_a),
        .i_CMD_ADDR (addr_a), .i_CMD_DATA (data_a),
        .o_CS_n (cs_a), .o_WR_n (wr_a), .o_A0 (a0_a), .o_D (d_a),
        .o_BUSY (busy_a), .o_LEVEL (level_a)
    );

    opm_write_sequencer #(
        .FIFO_DEPTH (4), .SETUP_CYC (1), .STROBE_CYC (1), .HOLD_CYC (1), .GAP_CYC (0)
    ) dut_b (
        .i_EMUCLK (clk), .i_RST_n (rst_b),
        .i_CMD_VALID (valid_b), .o_CMD_READY (ready_b),
        .i_CMD_ADDR (addr_b), .i_CMD_DATA (data_b),
        .o_CS_n (cs_b), .o_WR_n (wr_b), .o_A0 (a0_b), .o_D (d_b),
        .o_BUSY (busy_b), .o_LEVEL (level_b)
    );

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int p_setup[2]  = '{15, 1};
    int p_strobe[2] = '{20, 1};
    int p_hold[2]   = '{15, 1};

    logic       m_prev_cs[2];
    logic       m_prev_a0[2];
    logic [7:0] m_prev_d[2];
    int         m_setup[2], m_strobe[2];
    bit         m_unstable[2], m_a_unstable[2], m_have_addr[2];
    logic [7:0] m_addr[2];
    int         m_a_setup[2], m_a_strobe[2], m_a_rise[2];
    int         m_addr_fall[2], m_d_fall[2], m_cur_cmd_fall[2], m_prev_cmd_fall[2];
    int         m_fall_cnt[2] = '{0, 0};

    int last_push_edge;
    int fc, e1, t;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic phaseEnd(input int id);
        exp_t e;
        bit   have;
        if (!m_prev_a0[id]) begin
            checkOutput($sformatf("addr_phase_pending[%0d]", id), m_have_addr[id], 0);
            m_have_addr[id]  = 1'b1;
            m_addr[id]       = m_prev_d[id];
            m_a_setup[id]    = m_setup[id];
            m_a_strobe[id]   = m_strobe[id];
            m_a_rise[id]     = cyc;
            m_a_unstable[id] = m_unstable[id];
            m_cur_cmd_fall[id] = m_addr_fall[id];
        end else begin
            checkOutput($sformatf("data_after_addr[%0d]", id), m_have_addr[id], 1);
            m_have_addr[id] = 1'b0;
            have = 1'b0;
            if (id == 0) begin
                have = (exp_q0.size() > 0);
                if (have) e = exp_q0.pop_front();
            end else begin
                have = (exp_q1.size() > 0);
                if (have) e = exp_q1.pop_front();
            end
            checkOutput($sformatf("cmd_expected[%0d]", id), have, 1);
            if (have) begin
                checkOutput($sformatf("bus_addr[%0d]", id), m_addr[id], e.addr);
                checkOutput($sformatf("bus_data[%0d]", id), m_prev_d[id], e.data);
                checkOutput($sformatf("a_setup[%0d]", id), m_a_setup[id], p_setup[id]);
                checkOutput($sformatf("a_strobe[%0d]", id), m_a_strobe[id], p_strobe[id]);
                checkOutput($sformatf("d_setup[%0d]", id), m_setup[id], p_setup[id]);
                checkOutput($sformatf("d_strobe[%0d]", id), m_strobe[id], p_strobe[id]);
                checkOutput($sformatf("a_hold[%0d]", id), m_d_fall[id] - m_a_rise[id], p_hold[id]);
                checkOutput($sformatf("a0_d_stable[%0d]", id), m_a_unstable[id] | m_unstable[id], 0);
                if (e.spacing != 0) begin
                    checkOutput($sformatf("cmd_spacing[%0d]", id),
                                m_cur_cmd_fall[id] - m_prev_cmd_fall[id], e.spacing);
                end
            end
            m_prev_cmd_fall[id] = m_cur_cmd_fall[id];
        end
    endtask

    task automatic monitorStep(input int id, input logic rst_n, input logic cs_n,
                               input logic wr_n, input logic a0, input logic [7:0] d);
        if (!rst_n) begin
            m_prev_cs[id]   = 1'b1;
            m_prev_a0[id]   = 1'b0;
            m_prev_d[id]    = 8'h00;
            m_have_addr[id] = 1'b0;
            m_setup[id]     = 0;
            m_strobe[id]    = 0;
            m_unstable[id]  = 1'b0;
            return;
        end
        if (m_prev_cs[id] && !cs_n) begin
            m_fall_cnt[id]++;
            checkOutput($sformatf("wr_high_at_cs_fall[%0d]", id), wr_n, 1);
            m_setup[id]    = 0;
            m_strobe[id]   = 0;
            m_unstable[id] = 1'b0;
            if (!a0) m_addr_fall[id] = cyc;
            else     m_d_fall[id] = cyc;
        end
        if (!cs_n) begin
            if (!m_prev_cs[id] && (a0 != m_prev_a0[id] || d != m_prev_d[id])) m_unstable[id] = 1'b1;
            if (wr_n) m_setup[id]++;
            else      m_strobe[id]++;
        end
        if (!m_prev_cs[id] && cs_n) phaseEnd(id);
        m_prev_cs[id] = cs_n;
        m_prev_a0[id] = a0;
        m_prev_d[id]  = d;
    endtask

    always @(negedge clk) monitorStep(0, rst_a, cs_a, wr_a, a0_a, d_a);
    always @(negedge clk) monitorStep(1, rst_b, cs_b, wr_b, a0_b, d_b);

    // Starts and ends on a falling edge; records the rising edge that accepted the command
    task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] dv,
                                 input int spacing);
        exp_t e;
        int   waited;
        e.addr = a; e.data = dv; e.spacing = spacing;
        if (id == 0) begin valid_a = 1'b1; addr_a = a; data_a = dv; end
        else         begin valid_b = 1'b1; addr_b = a; data_b = dv; end
        waited = 0;
        while (((id == 0) ? ready_a : ready_b) == 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput($sformatf("push_accepted[%0d]", id), (id == 0) ? ready_a : ready_b, 1);
        if (((id == 0) ? ready_a : ready_b) == 1'b1) begin
            last_push_edge = cyc + 1;
            if (id == 0) exp_q0.push_back(e);
            else         exp_q1.push_back(e);
        end
        @(negedge clk);
        if (id == 0) valid_a = 1'b0;
        else         valid_b = 1'b0;
    endtask

    task automatic waitBusyLow(input int id, input int bound, output int when);
        when = -1;
        @(negedge clk);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (((id == 0) ? busy_a : busy_b) == 1'b0) begin
                when = cyc;
                break;
            end
        end
        checkOutput($sformatf("busy_cleared[%0d]", id), (id == 0) ? busy_a : busy_b, 0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        valid_a = 1'b0; addr_a = 8'h00; data_a = 8'h00;
        valid_b = 1'b0; addr_b = 8'h00; data_b = 8'h00;
        repeat (4) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_cs_n", cs_a, 1);
        checkOutput("rst_wr_n", wr_a, 1);
        checkOutput("rst_a0", a0_a, 0);
        checkOutput("rst_d", d_a, 8'h00);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_ready", ready_a, 1);
        checkOutput("rst_level", level_a, 0);

        $display("[TB] single write 0x18 <= 0xFF");
        fc = m_fall_cnt[0];
        applyStimulus(0, 8'h18, 8'hFF, 0);
        for (int k = 0; k < 10 && m_fall_cnt[0] == fc; k++) @(negedge clk);
        checkOutput("cs_fall_seen", m_fall_cnt[0] != fc, 1);
        checkOutput("first_cs_latency", m_addr_fall[0] - last_push_edge, 2);
        e1 = m_addr_fall[0];
        waitBusyLow(0, 400, t);
        checkOutput("busy_clear_delay", t - e1, 164);

        $display("[TB] four back-to-back writes");
        applyStimulus(0, 8'h18, 8'hFF, 0);
        applyStimulus(0, 8'h1B, 8'h01, 164);
        applyStimulus(0, 8'h28, 8'h3A, 164);
        applyStimulus(0, 8'h38, 8'h70, 164);
        waitBusyLow(0, 800, t);

        $display("[TB] ten writes with valid held high");
        for (int i = 0; i < 9; i++) applyStimulus(0, 8'h20 + 8'(i), 8'hA0 + 8'(i), (i == 0) ? 0 : 164);
        checkOutput("full_level", level_a, 8);
        checkOutput("full_ready", ready_a, 0);
        e1 = m_addr_fall[0];
        applyStimulus(0, 8'h29, 8'hA9, 164);
        checkOutput("tenth_accept_edge", last_push_edge - e1, 164);
        waitBusyLow(0, 1900, t);

        $display("[TB] push on the pop edge at level 7");
        for (int i = 0; i < 8; i++) applyStimulus(0, 8'h50 + 8'(i), 8'h60 + 8'(i), (i == 0) ? 0 : 164);
        e1 = m_addr_fall[0];
        for (int k = 0; k < 400 && cyc != e1 + 162; k++) @(negedge clk);
        checkOutput("level_before_simul", level_a, 7);
        applyStimulus(0, 8'h58, 8'h68, 164);
        checkOutput("level_after_simul", level_a, 7);
        waitBusyLow(0, 1700, t);

        $display("[TB] minimal timing, no gap");
        applyStimulus(1, 8'h01, 8'h11, 0);
        applyStimulus(1, 8'h02, 8'h22, 6);
        applyStimulus(1, 8'h03, 8'h33, 6);
        waitBusyLow(1, 100, t);

        $display("[TB] reset during data strobe");
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h70 + 8'(i), 8'h80 + 8'(i), 0);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (a0_a && !wr_a) break;
        end
        checkOutput("dstrobe_reached", a0_a & ~wr_a, 1);
        checkOutput("queued_before_reset", level_a, 3);
        #2 rst_a = 1'b0;
        #1;
        checkOutput("arst_cs_n", cs_a, 1);
        checkOutput("arst_wr_n", wr_a, 1);
        checkOutput("arst_a0", a0_a, 0);
        checkOutput("arst_d", d_a, 8'h00);
        checkOutput("arst_level", level_a, 0);
        checkOutput("arst_busy", busy_a, 0);
        checkOutput("arst_ready", ready_a, 1);
        exp_q0.delete();
        fc = m_fall_cnt[0];
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        repeat (400) @(negedge clk);
        checkOutput("no_strobe_after_reset", m_fall_cnt[0] - fc, 0);
        checkOutput("post_reset_busy", busy_a, 0);

        checkOutput("exp_q0_drained", exp_q0.size(), 0);
        checkOutput("exp_q1_drained", exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
